alu_addsub_iter: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_addsub_iter_if.sv | 26 ++
 rtl/alu_chunk_add.sv | 15 +
 rtl/alu_addsub_iter.sv | 123 ++++++++++++
 tb/tb_alu_addsub_iter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, FSM states, op encoding.
// Imported by the iterative adder, the ALU top and related benches.
package alu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_addsub_iter_if.sv
// Handshake and result bundle for the iterative adder/subtractor.
// master drives operands and start; slave returns status and flags.
interface alu_addsub_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             z;
    logic             v;
    logic             n;

    modport master (
        output start, sub, a, b,
        input  ready, done, s, z, v, n
    );

    modport slave (
        input  start, sub, a, b,
        output ready, done, s, z, v, n
    );
endinterface

// File: rtl/alu_chunk_add.sv
// One CHUNK-bit slice adder with carry in and carry out.
// Purely combinational; the parent selects which slice feeds it.
module alu_chunk_add #(
    parameter int CHUNK = 8
) (
    input  logic             cin,
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + (CHUNK+1)'(cin);

endmodule

// File: rtl/alu_addsub_iter.sv
// Iterative add/sub: one CHUNK slice per clock, Z/V/N flags at the end.
// Results and flags stay registered until the next operation finishes.
module alu_addsub_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    alu_addsub_iter_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nx;
    logic             carry;
    logic             zacc;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] r;
    logic             cout;
    logic             last;
    logic             accept;

    logic [WIDTH-1:0] s_q;
    logic             z_q;
    logic             v_q;
    logic             n_q;

    assign x      = opa[idx*CHUNK +: CHUNK];
    assign y      = opb[idx*CHUNK +: CHUNK];
    assign last   = (idx == IW'(NCHUNK - 1));
    assign accept = bus.start && bus.ready;

    alu_chunk_add #(
        .CHUNK (CHUNK)
    ) u_add (
        .cin  (carry),
        .x    (x),
        .y    (y),
        .sum  (r),
        .cout (cout)
    );

    // Shadow sum with the current slice merged in
    always_comb begin
        shadow_nx = shadow;
        shadow_nx[idx*CHUNK +: CHUNK] = r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state: FIN accepts a new start for back-to-back ops
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = FIN;
            FIN:     state_nx = bus.start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        bus.ready = (state != RUN);
        bus.done  = (state == FIN);
    end

    // Operand latch, slice iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            opa    <= '0;
            opb    <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            zacc   <= 1'b1;
            idx    <= '0;
            s_q    <= '0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
        end else if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b ^ {WIDTH{bus.sub == OP_SUB}};
            carry <= bus.sub;
            idx   <= '0;
            zacc  <= 1'b1;
        end else if (state == RUN) begin
            shadow <= shadow_nx;
            zacc   <= zacc & (r == '0);
            carry  <= cout;
            idx    <= idx + 1'b1;
            if (last) begin
                s_q <= shadow_nx;
                z_q <= zacc & (r == '0);
                n_q <= r[CHUNK-1];
                v_q <= (x[CHUNK-1] == y[CHUNK-1]) &&
                       (r[CHUNK-1] != x[CHUNK-1]);
            end
        end
    end

    assign bus.s = s_q;
    assign bus.z = z_q;
    assign bus.v = v_q;
    assign bus.n = n_q;

endmodule

// File: tb/tb_alu_addsub_iter.sv
// Directed bench for alu_addsub_iter: vector table plus
// hand-written sequences for ignored start, back-to-back and reset.
module tb_alu_addsub_iter;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_addsub_iter_if #(.WIDTH(32)) bus ();

    alu_addsub_iter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic sub_i);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a_i;
        bus.b     = b_i;
        bus.sub   = sub_i;
    endtask

    // Counts negedges from the launch negedge until done is seen.
    task automatic wait_done(input bit drop, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (drop && k == 0) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=none exp=done");
        end
    endtask

    int          lat;
    int          ndone;
    logic [31:0] sv;

    initial begin
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        reset     = 1'b1;

        vecs[0] = '{32'h5,        32'h5,        1'b1, 32'h0,        1, 0, 0};
        vecs[1] = '{32'h7FFFFFFF, 32'h1,        1'b0, 32'h80000000, 0, 1, 1};
        vecs[2] = '{32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 0, 1, 0};
        vecs[3] = '{32'h3,        32'h5,        1'b1, 32'hFFFFFFFE, 0, 0, 1};
        vecs[4] = '{32'h000000FF, 32'h1,        1'b0, 32'h00000100, 0, 0, 0};
        vecs[5] = '{32'hFFFFFFFF, 32'h1,        1'b0, 32'h0,        1, 0, 0};
        vecs[6] = '{32'h12345678, 32'h0FEDCBA9, 1'b0, 32'h22222221, 0, 0, 0};
        vecs[7] = '{32'h0,        32'h1,        1'b1, 32'hFFFFFFFF, 0, 0, 1};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h0,        1, 1, 0};

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done",  32'(bus.done),  32'd0);
        check("rst_s",     bus.s,          32'd0);
        check("rst_zvn",   {29'd0, bus.z, bus.v, bus.n}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(1'b1, lat);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'd5);
            check($sformatf("v%0d_s", i), bus.s, vecs[i].s);
            check($sformatf("v%0d_zvn", i),
                  {29'd0, bus.z, bus.v, bus.n},
                  {29'd0, vecs[i].z, vecs[i].v, vecs[i].n});
            check($sformatf("v%0d_ready", i), 32'(bus.ready), 32'd1);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_hold", i), bus.s, vecs[i].s);
        end

        // Start pulsed during RUN with other operands must be ignored
        launch(32'd100, 32'd23, 1'b0);
        @(negedge clk);
        check("ign_busy", 32'(bus.ready), 32'd0);
        bus.a   = 32'd1;
        bus.b   = 32'd1;
        bus.sub = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        sv    = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                sv = bus.s;
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_s", sv, 32'd123);

        // Back-to-back: start held through FIN
        launch(32'd10, 32'd20, 1'b0);
        @(negedge clk);
        bus.a   = 32'd7;
        bus.b   = 32'd7;
        bus.sub = 1'b1;
        wait_done(1'b0, lat);
        check("b2b_lat1", 32'(lat), 32'd4);
        check("b2b_s1", bus.s, 32'd30);
        check("b2b_z1", 32'(bus.z), 32'd0);
        wait_done(1'b1, lat);
        check("b2b_gap", 32'(lat), 32'd5);
        check("b2b_s2", bus.s, 32'd0);
        check("b2b_z2", 32'(bus.z), 32'd1);

        // Reset in the second RUN cycle aborts the operation
        launch(32'h1234, 32'h1, 1'b0);
        wait_done(1'b1, lat);
        check("pre_s", bus.s, 32'h1235);
        @(negedge clk);
        launch(32'hAAAA0000, 32'h1111, 1'b0);
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.done) ndone++;
        @(negedge clk);
        if (bus.done) ndone++;
        reset = 1'b1;
        @(negedge clk);
        check("ab_ready", 32'(bus.ready), 32'd1);
        check("ab_s", bus.s, 32'd0);
        check("ab_zvn", {29'd0, bus.z, bus.v, bus.n}, 32'd0);
        if (bus.done) ndone++;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("ab_nodone", 32'(ndone), 32'd0);
        launch(32'd1, 32'd1, 1'b0);
        wait_done(1'b1, lat);
        check("ab_fresh_s", bus.s, 32'd2);
        check("ab_fresh_lat", 32'(lat), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
